// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
//
// Round-robin arbiter that lets CORE_COUNT cores share one single-port data
// memory with a 1-cycle synchronous read. The arbiter drives the memory write
// enable, address and write data combinationally from the current winner.
// It registers the returned read word and pulses a per-core read-valid.
//
// Optional feature (macro DMEM_ARB_LOCK_EN):
//   Adds the reqLock input. A winner accepted with reqLock set locks the
//   arbiter to itself, so it can run atomic read-modify-write sequences.
//
// Lock FSM (present only with DMEM_ARB_LOCK_EN):
//   state    | meaning
//   S_OPEN   | normal round-robin arbitration over all requesters
//   S_LOCKED | only r_owner may be granted; pointer frozen at r_owner+1
//
// Ports:
//   clk         system clock, rising edge
//   rstN        asynchronous active-low reset
//   req         per-core request, held until granted
//   reqWrEn     per-core write (1) / read (0)
//   reqAddr     packed per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   reqData     packed per-core write data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqLock     per-core lock request (DMEM_ARB_LOCK_EN only)
//   gnt         one-hot or zero combinational grant
//   rdValid     one-cycle pulse to the core whose read data is on rdData
//   rdData      registered read data, shared by all cores
//   memWrEn     memory write enable
//   memAddr     memory address
//   memDataIn   memory write data
//   memDataOut  memory registered read data
// -----------------------------------------------------------------------------
module dmem_rr_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CORE_COUNT-1:0]            req,
  input  logic [CORE_COUNT-1:0]            reqWrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] reqAddr,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] reqData,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [CORE_COUNT-1:0]            reqLock,
`endif
  output logic [CORE_COUNT-1:0]            gnt,
  output logic [CORE_COUNT-1:0]            rdValid,
  output logic [DATA_WIDTH-1:0]            rdData,
  output logic                             memWrEn,
  output logic [ADDR_WIDTH-1:0]            memAddr,
  output logic [DATA_WIDTH-1:0]            memDataIn,
  input  logic [DATA_WIDTH-1:0]            memDataOut
);

  localparam int PW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  logic [PW-1:0]           r_ptr;
  logic                    r_s1_valid;
  logic [CORE_COUNT-1:0]   r_s1_owner;
  logic                    r_s2_valid;
  logic [CORE_COUNT-1:0]   r_s2_owner;
  logic [DATA_WIDTH-1:0]   r_rd_data;

  logic [CORE_COUNT-1:0]   w_req_eff;
  logic                    w_found;
  logic [PW-1:0]           w_win;
  logic [CORE_COUNT-1:0]   w_gnt;
  logic                    w_rd_accept;
  logic [PW-1:0]           w_ptr_nxt;

  logic [ADDR_WIDTH-1:0]   w_addr_arr [CORE_COUNT];
  logic [DATA_WIDTH-1:0]   w_data_arr [CORE_COUNT];

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_unpack
    assign w_addr_arr[g] = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[g] = reqData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % CORE_COUNT);
  endfunction

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {
    S_OPEN   = 1'b0,
    S_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t           r_state;
  lock_state_t           w_state_nxt;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         w_owner_nxt;
  logic [CORE_COUNT-1:0] w_owner_oh;

  assign w_owner_oh = CORE_COUNT'(1) << r_owner;
  assign w_req_eff  = (r_state == S_LOCKED) ? (req & w_owner_oh) : req;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_OPEN;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      S_OPEN: begin
        if (w_found && reqLock[w_win]) begin
          w_state_nxt = S_LOCKED;
          w_owner_nxt = w_win;
        end
      end
      S_LOCKED: begin
        // Owner dropping req releases the lock even though nothing is accepted.
        if (!req[r_owner] || (w_found && !reqLock[r_owner])) begin
          w_state_nxt = S_OPEN;
        end
      end
      default: w_state_nxt = S_OPEN;
    endcase
  end
`else
  assign w_req_eff = req;
`endif

  // First set bit at or above the pointer, wrapping. Iterating from the far
  // end downward lets the nearest requester overwrite the result last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      if (w_req_eff[wrap_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(r_ptr, k);
      end
    end
  end

  assign w_gnt       = w_found ? (CORE_COUNT'(1) << w_win) : '0;
  assign w_rd_accept = w_found & ~reqWrEn[w_win];
  assign w_ptr_nxt   = (w_win == PW'(CORE_COUNT - 1)) ? '0 : w_win + PW'(1);

  assign gnt       = w_gnt;
  assign memWrEn   = w_found & reqWrEn[w_win];
  assign memAddr   = w_found ? w_addr_arr[w_win] : '0;
  assign memDataIn = w_found ? w_data_arr[w_win] : '0;

  // The pointer moves to winner+1 on every acceptance. While locked the
  // winner is always the owner, so the pointer already sits at owner+1 and
  // stays there; a release by req drop therefore needs no extra update.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_owner <= '0;
      r_s2_valid <= 1'b0;
      r_s2_owner <= '0;
      r_rd_data  <= '0;
    end else begin
      if (w_found) begin
        r_ptr <= w_ptr_nxt;
      end
      r_s1_valid <= w_rd_accept;
      r_s1_owner <= w_gnt;
      r_s2_valid <= r_s1_valid;
      r_s2_owner <= r_s1_owner;
      // Memory word for a stage-1 read is on memDataOut during this cycle.
      if (r_s1_valid) begin
        r_rd_data <= memDataOut;
      end
    end
  end

  assign rdValid = r_s2_valid ? r_s2_owner : '0;
  assign rdData  = r_rd_data;

endmodule
